// File: rtl/gpu_op_arbiter.sv
// gpu_op_arbiter
//
// Shares one GPU draw-op port between several op sources. Each source sees
// its own port with the same protocol it would see on a bare GPU:
// pulse req_op_valid for one ce-cycle, then wait for req_op_ready to return.
// The arbiter buffers one op per requester, picks among pending requesters
// round-robin, issues to the GPU, and keeps the owner's ready low until the
// GPU reports idle again.
//
// Handshake semantics (both sides):
//   Requester side: an op is captured on a ce cycle where req_op_valid[i] and
//   req_op_ready[i] are both high. A pulse while ready is low is dropped.
//   req_op_ready[i] is low from the cycle after capture until the cycle after
//   the GPU has finished that op.
//   GPU side: gpu_op_valid is a one-ce-cycle registered pulse and is only
//   raised while gpu_op_ready is high. After the pulse, gpu_op_ready is ignored
//   for one cycle (the GPU's chance to drop it), then its return to high marks
//   completion.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce             clock enable; all state holds while low
//   req_op         per-requester op
//   req_op_valid   per-requester one-ce-cycle op pulse
//   req_op_ready   per-requester: no buffered and no executing op
//   gpu_op         op to the GPU (holds after the pulse)
//   gpu_op_valid   one-ce-cycle issue pulse to the GPU
//   gpu_op_ready   GPU idle
//   busy           an op is issued or executing (FSM not idle)
//   grant          index of the last / current owner
//   ops_issued     wrapping count of issued ops
//   state_dbg      FSM state encoding (0 idle, 1 issue guard, 2 wait done)

package gpu_op_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] width;
        logic [7:0]  color;
    } gpu_op_t;
endpackage

module gpu_op_arbiter
    import gpu_op_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  gpu_op_t               req_op [REQUESTERS],
    input  logic [REQUESTERS-1:0] req_op_valid,
    output logic [REQUESTERS-1:0] req_op_ready,
    output gpu_op_t               gpu_op,
    output logic                  gpu_op_valid,
    input  logic                  gpu_op_ready,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant,
    output logic [15:0]           ops_issued,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE_GUARD = 2'd1,
        WAIT_DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [REQUESTERS-1:0] pending;
    gpu_op_t               op_buf [REQUESTERS];

    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic                  found_hi;
    logic [IDX_W-1:0]      hi_idx;
    logic [IDX_W-1:0]      lo_idx;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Ready is derived straight from registers, so it drops the cycle after
    // a capture and stays low while this requester's op is in the GPU.
    always_comb begin
        req_op_ready = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            req_op_ready[i] = !pending[i] && !(busy && grant == IDX_W'(i));
        end
    end

    // Round-robin from grant+1 upward with wrap: the lowest pending index
    // above grant wins; if there is none, the lowest pending index overall.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) > grant) begin
                    hi_idx   = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_valid = |pending;
        win_idx   = found_hi ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            gpu_op       <= '0;
            gpu_op_valid <= 1'b0;
            grant        <= IDX_W'(REQUESTERS - 1);
            ops_issued   <= '0;
        end else if (ce) begin
            // Captures run in every state. They cannot collide with the
            // issue below because a pending slot is never ready.
            for (int i = 0; i < REQUESTERS; i++) begin
                if (req_op_valid[i] && req_op_ready[i]) begin
                    pending[i] <= 1'b1;
                    op_buf[i]  <= req_op[i];
                end
            end

            case (state)
                IDLE: begin
                    if (win_valid && gpu_op_ready) begin
                        gpu_op           <= op_buf[win_idx];
                        gpu_op_valid     <= 1'b1;
                        pending[win_idx] <= 1'b0;
                        grant            <= win_idx;
                        ops_issued       <= ops_issued + 16'd1;
                        state            <= ISSUE_GUARD;
                    end
                end
                ISSUE_GUARD: begin
                    // gpu_op_ready may still show the pre-issue idle level
                    // here, so it is not looked at.
                    gpu_op_valid <= 1'b0;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (gpu_op_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Testbench for gpu_op_arbiter with three requesters. A small GPU model drops
// ready for GPU_BUSY ce-cycles after each accepted op. Ops are pushed onto a
// scoreboard in the order the arbiter must issue them; a monitor pops and
// compares on every rising edge of gpu_op_valid and also checks ops_issued.

module tb_gpu_op_arbiter;
    import gpu_op_pkg::*;

    localparam int R        = 3;
    localparam int IDX_W    = $clog2(R);
    localparam int W        = $bits(gpu_op_t);
    localparam int GPU_BUSY = 9;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ce  = 1'b1;
    gpu_op_t          req_op [R];
    logic [R-1:0]     req_op_valid = '0;
    logic [R-1:0]     req_op_ready;
    gpu_op_t          gpu_op;
    logic             gpu_op_valid;
    logic             gpu_op_ready = 1'b1;
    logic             busy;
    logic [IDX_W-1:0] grant;
    logic [15:0]      ops_issued;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    gpu_op_arbiter #(.REQUESTERS(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .req_op       (req_op),
        .req_op_valid (req_op_valid),
        .req_op_ready (req_op_ready),
        .gpu_op       (gpu_op),
        .gpu_op_valid (gpu_op_valid),
        .gpu_op_ready (gpu_op_ready),
        .busy         (busy),
        .grant        (grant),
        .ops_issued   (ops_issued),
        .state_dbg    (state_dbg)
    );

    // ---------------- GPU model ----------------
    // Accepts on a ce edge where gpu_op_valid is high, then shows not-ready
    // for GPU_BUSY cycles. It is not affected by rst.
    int gpu_cnt = 0;
    always @(posedge clk) begin
        if (ce) begin
            if (gpu_op_valid === 1'b1 && gpu_cnt == 0) begin
                gpu_op_ready <= 1'b0;
                gpu_cnt      <= GPU_BUSY;
            end else if (gpu_cnt > 1) begin
                gpu_cnt <= gpu_cnt - 1;
            end else if (gpu_cnt == 1) begin
                gpu_cnt      <= 0;
                gpu_op_ready <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          issue_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [15:0]  exp_cnt  = 16'd0;
    logic         prev_v   = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (rst) begin
            exp_cnt = 16'd0;
            prev_v  = 1'b0;
        end else begin
            if (gpu_op_valid === 1'b1 && !prev_v) begin
                issue_cnt = issue_cnt + 1;
                exp_cnt   = exp_cnt + 16'd1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got op %h, scoreboard empty (cycle %0d)", gpu_op, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (gpu_op !== mon_exp) begin
                        errors++;
                        $display("FAIL issue_op: got %h, want %h (cycle %0d)", gpu_op, mon_exp, cyc);
                    end
                end
                checks++;
                if (ops_issued !== exp_cnt) begin
                    errors++;
                    $display("FAIL ops_issued: got %0d, want %0d (cycle %0d)", ops_issued, exp_cnt, cyc);
                end
            end
            prev_v = (gpu_op_valid === 1'b1);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic gpu_op_t mk(input int x, input int y, input int w);
        gpu_op_t op;
        op.x     = 16'(x);
        op.y     = 16'(y);
        op.width = 16'(w);
        op.color = 8'($urandom_range(0, 255));
        return op;
    endfunction

    task automatic pulse(input logic [R-1:0] mask);
        req_op_valid = mask;
        step();
        req_op_valid = '0;
    endtask

    task automatic wait_idle();
        int t = 0;
        step();
        while (!(busy === 1'b0 && req_op_ready === {R{1'b1}} && gpu_op_ready === 1'b1) && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b ready=%b gpu_ready=%b, want idle", busy, req_op_ready, gpu_op_ready);
        end
    endtask

    task automatic wait_issues(input int target, input int budget);
        int t = 0;
        while (issue_cnt < target && t < budget) begin
            step();
            t++;
        end
        checks++;
        if (issue_cnt < target) begin
            errors++;
            $display("FAIL issue_timeout: got %0d issues, want %0d", issue_cnt, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b1;
        for (int i = 0; i < R; i++) req_op[i] = W'({$urandom(), $urandom()});
        req_op_valid = R'($urandom_range(1, 7));
        step(2);
        checks++; if (req_op_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b, want 111", req_op_ready); end
        checks++; if (gpu_op_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b, want 0", gpu_op_valid); end
        checks++; if (gpu_op !== '0)           begin errors++; $display("FAIL reset_op: got %h, want 0", gpu_op); end
        checks++; if (ops_issued !== 16'd0)    begin errors++; $display("FAIL reset_count: got %0d, want 0", ops_issued); end
        checks++; if (grant !== 2'd2)          begin errors++; $display("FAIL reset_grant: got %0d, want 2", grant); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (state_dbg !== 2'd0)      begin errors++; $display("FAIL reset_state: got %0d, want 0", state_dbg); end
        rst = 1'b0;
        req_op_valid = '0;
        step();
        checks++; if (req_op_ready !== 3'b111) begin errors++; $display("FAIL reset_no_capture: got %b, want 111", req_op_ready); end
    endtask

    task automatic test_single_op();
        logic exp_v, exp_r0, exp_b;
        wait_idle();
        req_op[0] = mk(5, 7, 34);
        exp_q.push_back(req_op[0]);
        req_op_valid = 3'b001;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) req_op_valid = '0;
            exp_v  = (k == 2);
            exp_r0 = (k >= 13);
            exp_b  = (k >= 2 && k <= 12);
            checks++; if (gpu_op_valid !== exp_v)     begin errors++; $display("FAIL single_valid: t+%0d got %b, want %b", k, gpu_op_valid, exp_v); end
            checks++; if (req_op_ready[0] !== exp_r0) begin errors++; $display("FAIL single_ready0: t+%0d got %b, want %b", k, req_op_ready[0], exp_r0); end
            checks++; if (busy !== exp_b)             begin errors++; $display("FAIL single_busy: t+%0d got %b, want %b", k, busy, exp_b); end
            if (k == 2) begin
                checks++; if (gpu_op.x !== 16'd5) begin errors++; $display("FAIL single_x: got %0d, want 5", gpu_op.x); end
            end
        end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d, want 0", grant); end
    endtask

    task automatic test_round_robin();
        int start;
        wait_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < R; i++) begin
            req_op[i] = mk(100 + i, 10 * i, 8);
            exp_q.push_back(req_op[i]);
        end
        start = issue_cnt;
        pulse(3'b111);
        wait_issues(start + 3, 200);
        wait_idle();
        checks++; if (grant !== 2'd2) begin errors++; $display("FAIL rr_grant_a: got %0d, want 2", grant); end

        req_op[1] = mk(111, 1, 1);
        exp_q.push_back(req_op[1]);
        pulse(3'b010);
        wait_issues(start + 4, 100);
        wait_idle();
        checks++; if (grant !== 2'd1) begin errors++; $display("FAIL rr_grant_b: got %0d, want 1", grant); end

        req_op[0] = mk(120, 2, 2);
        req_op[2] = mk(122, 3, 3);
        exp_q.push_back(req_op[2]);
        exp_q.push_back(req_op[0]);
        pulse(3'b101);
        wait_issues(start + 6, 100);
        wait_idle();
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rr_grant_c: got %0d, want 0", grant); end
    endtask

    task automatic test_ce_gating();
        wait_idle();
        req_op[2] = mk(200, 20, 4);
        exp_q.push_back(req_op[2]);
        req_op_valid = 3'b100;
        step();
        req_op_valid = '0;
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (gpu_op_valid !== 1'b0)   begin errors++; $display("FAIL ce_no_issue: got %b, want 0", gpu_op_valid); end
            checks++; if (req_op_ready[2] !== 1'b0) begin errors++; $display("FAIL ce_pending: got %b, want 0", req_op_ready[2]); end
        end
        ce = 1'b1;
        step();
        checks++; if (gpu_op_valid !== 1'b1) begin errors++; $display("FAIL ce_resume_issue: got %b, want 1", gpu_op_valid); end
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (gpu_op_valid !== 1'b1) begin errors++; $display("FAIL ce_valid_frozen: got %b, want 1", gpu_op_valid); end
        end
        ce = 1'b1;
        step();
        checks++; if (gpu_op_valid !== 1'b0) begin errors++; $display("FAIL ce_valid_drop: got %b, want 0", gpu_op_valid); end
        wait_idle();
    endtask

    task automatic test_reset_wait_done();
        int start;
        int t;
        wait_idle();
        req_op[0] = mk(300, 30, 5);
        req_op[1] = mk(301, 31, 5);
        exp_q.push_back(req_op[0]);
        start = issue_cnt;
        pulse(3'b011);
        wait_issues(start + 1, 50);
        step(2);
        checks++; if (state_dbg !== 2'd2)       begin errors++; $display("FAIL rwd_state: got %0d, want 2", state_dbg); end
        checks++; if (req_op_ready[1] !== 1'b0) begin errors++; $display("FAIL rwd_pending1: got %b, want 0", req_op_ready[1]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (req_op_ready !== 3'b111) begin errors++; $display("FAIL rwd_ready: got %b, want 111", req_op_ready); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rwd_busy: got %b, want 0", busy); end
        checks++; if (grant !== 2'd2)          begin errors++; $display("FAIL rwd_grant: got %0d, want 2", grant); end
        req_op[2] = mk(322, 32, 6);
        exp_q.push_back(req_op[2]);
        start = issue_cnt;
        pulse(3'b100);
        t = 0;
        while (gpu_op_ready === 1'b0 && t < 50) begin
            checks++; if (gpu_op_valid !== 1'b0) begin errors++; $display("FAIL rwd_early_issue: got %b, want 0", gpu_op_valid); end
            step();
            t++;
        end
        wait_issues(start + 1, 50);
        wait_idle();
    endtask

    task automatic test_counter_wrap();
        int start;
        wait_idle();
        force dut.ops_issued = 16'hFFFE;
        step();
        release dut.ops_issued;
        exp_cnt = 16'hFFFE;
        step();
        checks++; if (ops_issued !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h, want fffe", ops_issued); end
        req_op[0] = mk(400, 40, 7);
        req_op[1] = mk(401, 41, 7);
        exp_q.push_back(req_op[0]);
        exp_q.push_back(req_op[1]);
        start = issue_cnt;
        pulse(3'b011);
        wait_issues(start + 2, 100);
        wait_idle();
        checks++; if (ops_issued !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d, want 0", ops_issued); end
    endtask

    initial begin
        for (int i = 0; i < R; i++) req_op[i] = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_ce_gating();
        test_reset_wait_done();
        test_counter_wrap();
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d ops never issued, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
